// File: rtl/uart_pkg.sv
// Frame format shared by both ends of the serial link.
// Holds the state encoding, the default timing and the parity selection.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    localparam int unsigned DefClksPerBit = 434;  // 50 MHz / 115200
    localparam int unsigned DefDataBits   = 8;

    localparam bit ParityEven = 1'b0;
    localparam bit ParityOdd  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
// Dropping iEn clears the count so every bit starts from a fresh period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    output logic oTick
);

    localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign oTick = iEn && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (!iEn || oTick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// Serial transmitter: start bit, DATA_BITS data bits LSB first, parity bit, stop bit.
// Accepts one byte per iStart/oReady handshake; oTx is driven from a register.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned DATA_BITS    = DefDataBits,
    parameter bit          PARITY_ODD   = ParityEven
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [DATA_BITS-1:0] iData,
    output logic                 oReady,
    output logic                 oTx,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int unsigned     IdxW    = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .iClk (iClk),
        .iRst (iRst),
        .iEn  (state_q != StIdle),
        .oTick(tick)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    state_d  = StStart;
                    shift_d  = iData;
                    parity_d = (^iData) ^ PARITY_ODD;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LastIdx) begin
                        state_d = StParity;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is decoded from the next state so the pin changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
        oTx    = tx_q;
        oReady = (state_q == StIdle);
        oBusy  = (state_q != StIdle);
        oDone  = (state_q == StStop) && tick;
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: table of frames plus hand-written corner sequences.
// Three instances cover even parity, odd parity and full-rate bit timing.
module tb_uart_transmitter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data;
    int         sel;

    logic start_a, start_b, start_c;
    logic tx_a, tx_b, tx_c, rdy_a, rdy_b, rdy_c, bsy_a, bsy_b, bsy_c, dn_a, dn_b, dn_c;
    logic tx_m, ready_m, busy_m, done_m;

    int tests;
    int failed;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_ODD(1'b0)) u_even (
        .iClk(clk), .iRst(rst), .iStart(start_a), .iData(data),
        .oReady(rdy_a), .oTx(tx_a), .oBusy(bsy_a), .oDone(dn_a)
    );

    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_ODD(1'b1)) u_odd (
        .iClk(clk), .iRst(rst), .iStart(start_b), .iData(data),
        .oReady(rdy_b), .oTx(tx_b), .oBusy(bsy_b), .oDone(dn_b)
    );

    uart_transmitter #(.CLKS_PER_BIT(434), .DATA_BITS(8), .PARITY_ODD(1'b0)) u_long (
        .iClk(clk), .iRst(rst), .iStart(start_c), .iData(data),
        .oReady(rdy_c), .oTx(tx_c), .oBusy(bsy_c), .oDone(dn_c)
    );

    always_comb begin
        tx_m = tx_a; ready_m = rdy_a; busy_m = bsy_a; done_m = dn_a;
        case (sel)
            1: begin tx_m = tx_b; ready_m = rdy_b; busy_m = bsy_b; done_m = dn_b; end
            2: begin tx_m = tx_c; ready_m = rdy_c; busy_m = bsy_c; done_m = dn_c; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Sends one frame and checks it cycle by cycle from the first low cycle onwards.
    // exp[b] is the line level of bit b (start, 8 data LSB first, parity, stop).
    task automatic run_frame(input int s, input logic [7:0] d, input logic [10:0] exp,
                             input logic odd, input int cpb, input bit hold, input int inj,
                             input string nm);
        logic [7:0] rx;
        logic       rxp;
        int         held;
        int         done_cnt;
        int         done_at;
        int         hs_cnt;
        int         k;
        rx = '0; rxp = 1'b0; done_cnt = 0; done_at = -1; hs_cnt = 0;
        sel   = s;
        data  = d;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        for (int b = 0; b < 11; b++) begin
            held = 0;
            for (int c = 0; c < cpb; c++) begin
                k = b * cpb + c;
                if (tx_m === exp[b]) held++;
                if (done_m === 1'b1) begin
                    done_cnt++;
                    done_at = k;
                end
                if (ready_m === 1'b0 && busy_m === 1'b1) hs_cnt++;
                if (c == cpb / 2) begin
                    if (b >= 1 && b <= 8) rx[b-1] = tx_m;
                    if (b == 9) rxp = tx_m;
                end
                if (inj >= 0 && k == inj) begin
                    start = 1'b1;
                    data  = 8'hFF;
                end else if (inj >= 0 && k == inj + 1) begin
                    start = 1'b0;
                end
                step();
            end
            check($sformatf("%s bit%0d cycles", nm, b), held, cpb);
        end
        check($sformatf("%s done count", nm), done_cnt, 1);
        check($sformatf("%s done position", nm), done_at, 11 * cpb - 1);
        check($sformatf("%s busy/not-ready cycles", nm), hs_cnt, 11 * cpb);
        check($sformatf("%s post-frame {tx,ready,busy,done}", nm),
              {28'd0, tx_m, ready_m, busy_m, done_m}, 32'b1100);
        check($sformatf("%s rx byte", nm), {24'd0, rx}, {24'd0, d});
        check($sformatf("%s rx parity", nm), {31'd0, (^rx) ^ rxp}, {31'd0, odd});
    endtask

    typedef struct {
        logic [7:0]  data;
        int          inst;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[6];
    int   idle_cnt;

    initial begin
        tests = 0; failed = 0;
        rst = 1'b1; start = 1'b0; data = 8'h00; sel = 0;

        vecs[0] = '{data: 8'hA5, inst: 0, exp: {1'b1, 1'b0, 8'hA5, 1'b0}};
        vecs[1] = '{data: 8'h01, inst: 0, exp: {1'b1, 1'b1, 8'h01, 1'b0}};
        vecs[2] = '{data: 8'h01, inst: 1, exp: {1'b1, 1'b0, 8'h01, 1'b0}};
        vecs[3] = '{data: 8'hFF, inst: 0, exp: {1'b1, 1'b0, 8'hFF, 1'b0}};
        vecs[4] = '{data: 8'h07, inst: 1, exp: {1'b1, 1'b0, 8'h07, 1'b0}};
        vecs[5] = '{data: 8'h80, inst: 1, exp: {1'b1, 1'b0, 8'h80, 1'b0}};

        #2;
        check("reset async {tx,ready,busy,done}", {28'd0, tx_a, rdy_a, bsy_a, dn_a}, 32'b1100);
        step();
        step();
        check("reset held {tx,ready,busy,done}", {28'd0, tx_b, rdy_b, bsy_b, dn_b}, 32'b1100);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].inst, vecs[i].data, vecs[i].exp, vecs[i].inst == 1, 4, 1'b0, -1,
                      $sformatf("vec%0d", i));
        end

        // Back-to-back: iStart stays high, one idle-high cycle between the frames.
        run_frame(0, 8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}, 1'b0, 4, 1'b1, -1, "b2b first");
        run_frame(0, 8'hC3, {1'b1, 1'b0, 8'hC3, 1'b0}, 1'b0, 4, 1'b0, -1, "b2b second");

        // Busy ignore: an FF request during the data bits of a 00 frame is dropped.
        run_frame(0, 8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, 1'b0, 4, 1'b0, 13, "busy ignore");
        idle_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (tx_a === 1'b1 && rdy_a === 1'b1 && bsy_a === 1'b0) idle_cnt++;
            step();
        end
        check("busy ignore no second frame", idle_cnt, 8);

        // Reset during data bit 3 of 55, then a clean 0F frame.
        sel = 0; data = 8'h55; start = 1'b1;
        step();
        start = 1'b0;
        repeat (17) step();
        check("mid-frame data bit3 level", {31'd0, tx_a}, 32'd0);
        check("mid-frame busy before reset", {31'd0, bsy_a}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid-frame reset {tx,ready,busy,done}", {28'd0, tx_a, rdy_a, bsy_a, dn_a},
              32'b1100);
        step();
        rst = 1'b0;
        step();
        run_frame(0, 8'h0F, {1'b1, 1'b0, 8'h0F, 1'b0}, 1'b0, 4, 1'b0, -1, "after reset");

        // Full-rate timing: 434 clocks per bit, 4774 clocks per frame.
        run_frame(2, 8'h80, {1'b1, 1'b1, 8'h80, 1'b0}, 1'b0, 434, 1'b0, -1, "long");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
